// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register addresses, edge-type encodings and edge selection helper for key_pio_in
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Per-bit qualifying edges between the previous and next conditioned level.
    function automatic logic [31:0] edge_sel(input logic [31:0] prev,
                                             input logic [31:0] nxt,
                                             input int          edge_type);
        logic [31:0] res;
        res = '0;
        if (edge_type == int'(EDGE_RISE)) begin
            res = ~prev & nxt;
        end else if (edge_type == int'(EDGE_FALL)) begin
            res = prev & ~nxt;
        end else begin
            res = prev ^ nxt;
        end
        return res;
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// rtl/pio_debounce.sv - one-bit debouncer: level follows input after DEBOUNCE_CYCLES stable differing cycles
module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic level_next
);
    import pio_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (din != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                lvl_d = din;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Level and counter state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign level      = lvl_q;
    assign level_next = lvl_d;

endmodule

// File: rtl/key_pio_in.sv
// rtl/key_pio_in.sv - Avalon-MM input PIO with edge capture and IRQ; optional debounce under KEY_PIO_DEBOUNCE_EN
module key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    import pio_pkg::*;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] cur_lvl;
    logic [WIDTH-1:0] nxt_lvl;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

`ifdef KEY_PIO_DEBOUNCE_EN
    // Each bit is conditioned by its own debouncer holding the level register.
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk        (clk),
            .reset_n    (reset_n),
            .din        (sync2_q[i]),
            .level      (cur_lvl[i]),
            .level_next (nxt_lvl[i])
        );
    end
`else
    logic [WIDTH-1:0] lvl_q;

    // Without debounce the level simply trails the synchroniser by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= sync2_q;
        end
    end

    assign cur_lvl = lvl_q;
    assign nxt_lvl = sync2_q;
`endif

    assign wr_en = chipselect && !write_n;
    assign edges = WIDTH'(edge_sel(32'(cur_lvl), 32'(nxt_lvl), EDGE_TYPE));
    assign clr   = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata : '0;

    // Next-state for synchroniser, mask, edge capture (set beats clear) and read mux.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        mask_d  = (wr_en && address == PIO_ADDR_IRQMASK) ? writedata : mask_q;
        ecap_d  = (ecap_q & ~clr) | edges;
        case (address)
            PIO_ADDR_DATA:    rdata_d = cur_lvl;
            PIO_ADDR_IRQMASK: rdata_d = mask_q;
            PIO_ADDR_EDGECAP: rdata_d = ecap_q;
            default:          rdata_d = '0;
        endcase
    end

    // Register state; everything, including pending captures, clears on reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            mask_q  <= '0;
            ecap_q  <= '0;
            rdata_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            mask_q  <= mask_d;
            ecap_q  <= ecap_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_key_pio_in.sv
// tb/tb_key_pio_in.sv - self-checking bench for key_pio_in (table vectors, model-checked random, KEY_PIO_DEBOUNCE_EN test)
module tb_key_pio_in;

    localparam int W  = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [W-1:0] writedata;
    logic [W-1:0] readdata;
    logic [W-1:0] in_port;
    logic         irq;

    int total = 0;
    int bad   = 0;

    // Reference model: pins reach the level two edges after they are presented.
    bit           model_en = 1'b0;
    logic [W-1:0] m_lvl, m_mask, m_ecap, m_rd;
    logic [W-1:0] m_pins[$];

    always #5 clk = ~clk;

    key_pio_in #(
        .WIDTH           (W),
        .EDGE_TYPE       (1),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    typedef struct {
        logic [1:0]   a;
        logic         w;
        logic [W-1:0] wd;
        logic [W-1:0] p;
        logic [W-1:0] rd;
        logic         irq;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input logic rn, input logic [1:0] a, input logic wr,
                              input logic [W-1:0] wd, input logic [W-1:0] p);
        logic [W-1:0] nl;
        if (!rn) begin
            m_lvl  = '0;
            m_mask = '0;
            m_ecap = '0;
            m_rd   = '0;
            m_pins = {4'h0, 4'h0};
        end else begin
            m_rd = (a == 2'd0) ? m_lvl : (a == 2'd2) ? m_mask : (a == 2'd3) ? m_ecap : '0;
            m_pins.push_back(p);
            nl = m_pins.pop_front();
            if (wr && a == 2'd3) m_ecap = m_ecap & ~wd;
            m_ecap = m_ecap | (m_lvl & ~nl);
            if (wr && a == 2'd2) m_mask = wd;
            m_lvl = nl;
        end
    endtask

    task automatic step(input logic rn, input logic [1:0] a, input logic cs, input logic w,
                        input logic [W-1:0] wd, input logic [W-1:0] p);
        reset_n    = rn;
        address    = a;
        chipselect = cs;
        write_n    = !w;
        writedata  = wd;
        in_port    = p;
        @(posedge clk);
        if (model_en) model_edge(rn, a, cs && w, wd, p);
        #1;
        if (model_en) begin
            chk("model_readdata", readdata, m_rd);
            chk("model_irq", irq, |(m_ecap & m_mask));
        end
    endtask

    initial begin
        vec_t tbl[$];
        logic [W-1:0] pins;
        logic rn, cs, w;

        // Test 1: reset with pins high, level appears after the pipeline fills.
        model_en = (DB == 0);
        step(1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 4'hF);
        step(1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 4'hF);
        chk("reset_readdata", readdata, 4'h0);
        chk("reset_irq", irq, 1'b0);
        for (int i = 1; i <= 3 + DB; i++) begin
            step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 4'hF);
            if (i == 3 + DB) chk("data_before_settle", readdata, 4'h0);
        end
        step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 4'hF);
        chk("data_after_settle", readdata, 4'hF);
        step(1'b1, 2'd3, 1'b1, 1'b1, 4'hF, 4'hF);
        step(1'b1, 2'd3, 1'b1, 1'b0, 4'h0, 4'hF);
        chk("edgecap_cleared", readdata, 4'h0);
        chk("irq_after_clear", irq, 1'b0);

`ifndef KEY_PIO_DEBOUNCE_EN
        // Directed vectors: falling capture, W1C, set-beats-clear, mask gating.
        tbl = '{
            '{2'd2, 1'b1, 4'h1, 4'hF, 4'h0, 1'b0},
            '{2'd2, 1'b0, 4'h0, 4'hF, 4'h1, 1'b0},
            '{2'd0, 1'b0, 4'h0, 4'hE, 4'hF, 1'b0},
            '{2'd0, 1'b0, 4'h0, 4'hE, 4'hF, 1'b0},
            '{2'd0, 1'b0, 4'h0, 4'hE, 4'hF, 1'b1},
            '{2'd0, 1'b0, 4'h0, 4'hE, 4'hE, 1'b1},
            '{2'd3, 1'b0, 4'h0, 4'hE, 4'h1, 1'b1},
            '{2'd3, 1'b1, 4'h1, 4'hE, 4'h1, 1'b0},
            '{2'd3, 1'b0, 4'h0, 4'hE, 4'h0, 1'b0},
            '{2'd1, 1'b1, 4'hF, 4'hE, 4'h0, 1'b0},
            '{2'd2, 1'b1, 4'h0, 4'hE, 4'h1, 1'b0},
            '{2'd2, 1'b0, 4'h0, 4'hA, 4'h0, 1'b0},
            '{2'd2, 1'b0, 4'h0, 4'hE, 4'h0, 1'b0},
            '{2'd3, 1'b0, 4'h0, 4'hE, 4'h0, 1'b0},
            '{2'd3, 1'b0, 4'h0, 4'hE, 4'h4, 1'b0},
            '{2'd2, 1'b1, 4'h4, 4'hE, 4'h0, 1'b1},
            '{2'd0, 1'b0, 4'h0, 4'hE, 4'hE, 1'b1},
            '{2'd3, 1'b0, 4'h0, 4'hA, 4'h4, 1'b1},
            '{2'd3, 1'b0, 4'h0, 4'hA, 4'h4, 1'b1},
            '{2'd3, 1'b1, 4'h4, 4'hA, 4'h4, 1'b1},
            '{2'd3, 1'b0, 4'h0, 4'hA, 4'h4, 1'b1},
            '{2'd3, 1'b1, 4'h4, 4'hA, 4'h4, 1'b0},
            '{2'd3, 1'b0, 4'h0, 4'hA, 4'h0, 1'b0}
        };
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].a, 1'b1, tbl[i].w, tbl[i].wd, tbl[i].p);
            chk($sformatf("vec%0d_readdata", i), readdata, tbl[i].rd);
            chk($sformatf("vec%0d_irq", i), irq, tbl[i].irq);
        end

        // Test 5: reset while EDGECAP=A and IRQMASK=F wipes everything.
        step(1'b1, 2'd2, 1'b1, 1'b1, 4'hF, 4'hA);
        step(1'b1, 2'd3, 1'b1, 1'b1, 4'hF, 4'hA);
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        step(1'b1, 2'd3, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("pre_reset_edgecap", readdata, 4'hA);
        chk("pre_reset_irq", irq, 1'b1);
        step(1'b0, 2'd3, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("mid_reset_irq", irq, 1'b0);
        step(1'b1, 2'd3, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("post_reset_edgecap", readdata, 4'h0);
        step(1'b1, 2'd2, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("post_reset_mask", readdata, 4'h0);
        step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("post_reset_data", readdata, 4'h0);
        chk("post_reset_irq", irq, 1'b0);

        // Randomised traffic checked cycle by cycle against the model.
        pins = 4'hF;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) pins = pins ^ (4'h1 << $urandom_range(0, 3));
            rn = ($urandom_range(0, 149) != 0);
            cs = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 2) == 0);
            step(rn, 2'($urandom_range(0, 3)), cs, w, 4'($urandom), pins);
        end
`else
        // Test 6: a 5-cycle glitch is filtered; a held change lands at N+11.
        step(1'b1, 2'd2, 1'b1, 1'b1, 4'h1, 4'hF);
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, (k <= 5) ? 4'hE : 4'hF);
            chk($sformatf("glitch_irq_%0d", k), irq, 1'b0);
        end
        step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 4'hF);
        chk("glitch_data", readdata, 4'hF);
        step(1'b1, 2'd3, 1'b1, 1'b0, 4'h0, 4'hF);
        chk("glitch_edgecap", readdata, 4'h0);
        for (int k = 1; k <= 11; k++) begin
            step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 4'hE);
            chk($sformatf("held_irq_%0d", k), irq, (k == 11));
        end
        step(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 4'hE);
        chk("held_data", readdata, 4'hE);
        step(1'b1, 2'd3, 1'b1, 1'b0, 4'h0, 4'hE);
        chk("held_edgecap", readdata, 4'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
